// File: rtl/fir_da_pkg.sv
// Shared constants and types for the bit-serial distributed-arithmetic FIR engine.
package fir_da_pkg;

  localparam int DATA_W = 16;
  localparam int TAPS   = 8;
  localparam int ACC_W  = 32;
  localparam int K_W    = $clog2(DATA_W);

  localparam logic [K_W-1:0] K_LAST = K_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_e;

endpackage

// File: rtl/fir_da_tap_line.sv
// Sample delay line (tap0 = newest) exposing one bit-slice across all taps.
module fir_da_tap_line
  import fir_da_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              shift_en,
  input  logic [DATA_W-1:0] din,
  input  logic [K_W-1:0]    bit_idx,
  output logic [TAPS-1:0]   slice
);

  logic [DATA_W-1:0] r_taps [TAPS];

  // NOTE: the delay line is real filter state, so it is reset like any other
  // register; a stale history would corrupt the first outputs after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < TAPS; j++) r_taps[j] <= '0;
    end else if (shift_en) begin
      r_taps[0] <= din;
      for (int j = 1; j < TAPS; j++) r_taps[j] <= r_taps[j-1];
    end
  end

  // NOTE: assigning a default before the loop keeps this purely
  // combinational; any path that skips an assignment would infer a latch.
  always_comb begin
    slice = '0;
    for (int j = 0; j < TAPS; j++) slice[j] = r_taps[j][bit_idx];
  end

endmodule

// File: rtl/fir_da_mac_engine.sv
// Bit-serial DA MAC: one LUT lookup per sample bit, shift-accumulated into one output.
module fir_da_mac_engine
  import fir_da_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_sample,
  output logic [TAPS-1:0]   lut_addr,
  input  logic [ACC_W-1:0]  lut_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              busy
);

  state_e             r_state;
  state_e             w_next;
  logic [K_W-1:0]     r_k;
  logic [ACC_W-1:0]   r_acc;
  logic [ACC_W-1:0]   r_out;
  logic [TAPS-1:0]    w_slice;
  logic [ACC_W-1:0]   w_term;
  logic [ACC_W-1:0]   w_sum;
  logic               w_accept;
  logic               w_last;

  assign w_accept = in_valid && (r_state == IDLE);
  assign w_last   = (r_k == K_LAST);
  assign w_term   = lut_data << r_k;
  // Two's-complement weighting: the sign-bit slice carries weight -2^(DATA_W-1).
  assign w_sum    = w_last ? (r_acc - w_term) : (r_acc + w_term);

  fir_da_tap_line u_tap_line (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (w_accept),
    .din      (in_sample),
    .bit_idx  (r_k),
    .slice    (w_slice)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (in_valid) w_next = ACCUM;
      ACCUM:   if (w_last) w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k   <= '0;
      r_acc <= '0;
      r_out <= '0;
    end else if (w_accept) begin
      r_k   <= '0;
      r_acc <= '0;
    end else if (r_state == ACCUM) begin
      r_k   <= r_k + 1'b1;
      r_acc <= w_sum;
      if (w_last) r_out <= w_sum;
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign lut_addr  = (r_state == ACCUM) ? w_slice : '0;
  assign out_data  = r_out;

endmodule

// File: tb/tb_fir_da_mac_engine.sv
// Bench for fir_da_mac_engine: LUT model, arithmetic FIR reference, directed plus random runs.
module tb_fir_da_mac_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_sample = '0;
  logic [7:0]  lut_addr;
  logic [31:0] lut_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        busy;

  int tests = 0;
  int fails = 0;
  int cycle = 0;

  int coef [8] = '{1, 1, -5, -12, 22, 39, -62, -94};

  fir_da_mac_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sample (in_sample),
    .lut_addr  (lut_addr),
    .lut_data  (lut_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // External partial-sum LUT: sum of coefficients whose address bit is set.
  always_comb begin
    int s;
    s = 0;
    for (int j = 0; j < 8; j++) if (lut_addr[j]) s += coef[j];
    lut_data = 32'(s);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: bound expired, got no event expected event", name);
  endtask

  // Reference model: direct convolution over the accepted-sample history.
  int          hist [8];
  int          exp_out;
  int          accept_cycle;
  bit          pending;
  bit          prev_valid;
  logic [31:0] prev_data;

  function automatic int model_out();
    int s;
    s = 0;
    for (int j = 0; j < 8; j++) s += coef[j] * hist[j];
    return s;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int j = 0; j < 8; j++) hist[j] = 0;
      pending    = 0;
      prev_valid = 0;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_lut_addr", 32'(lut_addr), 32'd0);
      check("rst_out_data", out_data, 32'd0);
    end else begin
      check("in_ready_vs_busy", 32'(in_ready), 32'(!busy));
      if (!busy || out_valid) check("lut_addr_idle", 32'(lut_addr), 32'd0);
      if (out_valid) begin
        if (!prev_valid) begin
          if (!pending) fail_now("unexpected_out_valid");
          check("latency", 32'(cycle - accept_cycle), 32'd16);
          check("model_out_data", out_data, 32'(exp_out));
        end else begin
          check("out_data_stable", out_data, prev_data);
        end
      end
      if (in_valid && in_ready) begin
        for (int j = 7; j > 0; j--) hist[j] = hist[j-1];
        hist[0]      = int'($signed(in_sample));
        exp_out      = model_out();
        accept_cycle = cycle + 1;
        pending      = 1;
      end
      if (out_valid && out_ready) pending = 0;
      prev_valid = out_valid;
      prev_data  = out_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_valid(output bit ok);
    int n;
    n = 0;
    while (!out_valid && n < 60) begin
      tick();
      n++;
    end
    ok = out_valid;
  endtask

  task automatic send(input logic [15:0] s, input int stall, output logic [31:0] res);
    int n;
    bit ok;
    out_ready = (stall == 0);
    in_valid  = 1'b1;
    in_sample = s;
    n = 0;
    while (!in_ready && n < 60) begin
      tick();
      n++;
    end
    if (!in_ready) fail_now("accept_timeout");
    tick();
    in_valid = 1'b0;
    wait_valid(ok);
    if (!ok) fail_now("out_valid_timeout");
    res = out_data;
    repeat (stall) tick();
    out_ready = 1'b1;
    n = 0;
    while (out_valid && n < 10) begin
      tick();
      n++;
    end
  endtask

  initial begin
    logic [31:0] res;
    logic [31:0] held;
    bit          ok;
    int          imp [8] = '{1, 1, -5, -12, 22, 39, -62, -94};

    tick();
    reset_dut();

    // Impulse response reproduces the coefficient list.
    for (int i = 0; i < 8; i++) begin
      send((i == 0) ? 16'd1 : 16'd0, 0, res);
      check($sformatf("impulse_%0d", i), res, 32'(imp[i]));
    end

    // -1 sample: only tap0 bits set on every slice.
    reset_dut();
    in_valid  = 1'b1;
    in_sample = 16'hFFFF;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("neg_lut_addr_k%0d", i), 32'(lut_addr), 32'h01);
      tick();
    end
    check("neg_out_valid", 32'(out_valid), 32'd1);
    check("neg_out_data", out_data, 32'hFFFFFFFF);
    tick();

    // Step of 100: steady state is 100 * sum(b) = -11000.
    reset_dut();
    for (int i = 0; i < 8; i++) send(16'd100, 0, res);
    check("step_final", res, 32'hFFFFD508);

    // Most-negative sample reaching the last tap.
    reset_dut();
    for (int i = 0; i < 8; i++) send((i == 0) ? 16'h8000 : 16'd0, 0, res);
    check("minval_final", res, 32'h002F0000);

    // Backpressure in DONE with a sample waiting.
    reset_dut();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_sample = 16'd300;
    tick();
    in_valid = 1'b0;
    wait_valid(ok);
    if (!ok) fail_now("bp_out_valid_timeout");
    held      = out_data;
    check("bp_first", held, 32'd300);
    in_valid  = 1'b1;
    in_sample = 16'd7;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_data", out_data, held);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    check("bp_retired", 32'(out_valid), 32'd0);
    check("bp_ready_after", 32'(in_ready), 32'd1);
    tick();
    check("bp_accepted", 32'(busy), 32'd1);
    in_valid = 1'b0;
    wait_valid(ok);
    if (!ok) fail_now("bp_second_timeout");
    check("bp_second", out_data, 32'd307);
    tick();

    // Reset in the middle of accumulation clears the history too.
    in_valid  = 1'b1;
    in_sample = 16'd5;
    tick();
    in_valid = 1'b0;
    repeat (8) tick();
    check("pre_reset_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_lut_addr", 32'(lut_addr), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    send(16'd1, 0, res);
    check("post_reset_impulse", res, 32'd1);

    // Random samples, gaps and sink stalls, checked by the reference model.
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      send(16'($urandom), int'($urandom_range(0, 3)), res);
    end
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not complete, expected completion");
    $fatal(1);
  end

endmodule
